// File: rtl/alu_pkg.sv
// Shared definitions for the switch-bank ALU demonstrator: opcodes, flag
// positions and the hex digit to 7-segment glyph table.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;

  localparam int FLAG_ZF = 3;
  localparam int FLAG_CF = 2;
  localparam int FLAG_OF = 1;
  localparam int FLAG_SF = 0;

  // Segments are {dp,g,f,e,d,c,b,a}, active-low, dp always off.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0:    seg = 8'hC0;
      4'h1:    seg = 8'hF9;
      4'h2:    seg = 8'hA4;
      4'h3:    seg = 8'hB0;
      4'h4:    seg = 8'h99;
      4'h5:    seg = 8'h92;
      4'h6:    seg = 8'h82;
      4'h7:    seg = 8'hF8;
      4'h8:    seg = 8'h80;
      4'h9:    seg = 8'h90;
      4'hA:    seg = 8'h88;
      4'hB:    seg = 8'h83;
      4'hC:    seg = 8'hC6;
      4'hD:    seg = 8'hA1;
      4'hE:    seg = 8'h86;
      4'hF:    seg = 8'h8E;
      default: seg = 8'hFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational RV32I-style ALU producing the result and {ZF,CF,OF,SF}.
module alu
  import alu_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [3:0]  i_op,
  output logic [31:0] o_r,
  output logic [3:0]  o_f
);

  logic [32:0] w_sum;
  logic [32:0] w_diff;
  logic        w_of_add;
  logic        w_of_sub;
  logic [4:0]  w_sh;

  // Result mux; carry/overflow only meaningful for ADD/SUB, otherwise 0.
  always_comb begin
    w_sh     = i_b[4:0];
    w_sum    = {1'b0, i_a} + {1'b0, i_b};
    w_diff   = {1'b0, i_a} - {1'b0, i_b};
    w_of_add = (i_a[31] == i_b[31]) && (w_sum[31] != i_a[31]);
    w_of_sub = (i_a[31] != i_b[31]) && (w_diff[31] != i_a[31]);
    o_r      = 32'h0000_0000;
    o_f      = 4'b0000;
    case (i_op[2:0])
      3'b000: begin
        if (i_op[3]) begin
          o_r          = w_diff[31:0];
          o_f[FLAG_CF] = w_diff[32];
          o_f[FLAG_OF] = w_of_sub;
        end else begin
          o_r          = w_sum[31:0];
          o_f[FLAG_CF] = w_sum[32];
          o_f[FLAG_OF] = w_of_add;
        end
      end
      3'b001: o_r = i_a << w_sh;
      3'b010: o_r = {31'h0000_0000, ($signed(i_a) < $signed(i_b))};
      3'b011: o_r = {31'h0000_0000, (i_a < i_b)};
      3'b100: o_r = i_a ^ i_b;
      3'b101: begin
        if (i_op[3]) begin
          o_r = $unsigned($signed(i_a) >>> w_sh);
        end else begin
          o_r = i_a >> w_sh;
        end
      end
      3'b110: o_r = i_a | i_b;
      3'b111: o_r = i_a & i_b;
      default: o_r = 32'h0000_0000;
    endcase
    o_f[FLAG_ZF] = (o_r == 32'h0000_0000);
    o_f[FLAG_SF] = o_r[31];
  end

endmodule

// File: rtl/top.sv
// Board top: synchronised push-button loads of A/B/OP, registered ALU
// result and flags, and a scanned four-digit hex display of R[15:0].
module top
  import alu_pkg::*;
#(
  parameter int SCAN_BITS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_A,
  input  logic        clk_B,
  input  logic        clk_F,
  input  logic [31:0] SW,
  output logic [3:0]  F,
  output logic [3:0]  AN,
  output logic [7:0]  seg
);

  localparam logic [SCAN_BITS+1:0] SCAN_ONE = {{(SCAN_BITS+1){1'b0}}, 1'b1};

  logic [2:0]           r_sync1;
  logic [2:0]           r_sync2;
  logic [2:0]           r_prev;
  logic [2:0]           w_edge;
  logic [31:0]          r_a;
  logic [31:0]          r_b;
  logic [3:0]           r_op;
  logic [31:0]          r_r;
  logic [3:0]           r_f;
  logic [31:0]          w_alu_r;
  logic [3:0]           w_alu_f;
  logic [SCAN_BITS+1:0] r_scan;
  logic [1:0]           w_digit;
  logic [3:0]           w_nib;
  logic [3:0]           r_an;
  logic [7:0]           r_seg;

  // Bit order in the strobe vectors: [0]=A, [1]=B, [2]=OP.
  assign w_edge = r_sync2 & ~r_prev;

  // Strobe synchronisers and edge-detect history.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
      r_prev  <= 3'b000;
    end else begin
      r_sync1 <= {clk_F, clk_B, clk_A};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Operand and opcode capture, each on its own strobe edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a  <= 32'h0000_0000;
      r_b  <= 32'h0000_0000;
      r_op <= 4'b0000;
    end else begin
      if (w_edge[0]) r_a  <= SW;
      if (w_edge[1]) r_b  <= SW;
      if (w_edge[2]) r_op <= SW[3:0];
    end
  end

  alu u_alu (
    .i_a  (r_a),
    .i_b  (r_b),
    .i_op (r_op),
    .o_r  (w_alu_r),
    .o_f  (w_alu_f)
  );

  // Digit select and nibble pick for the current scan slot.
  always_comb begin
    w_digit = r_scan[SCAN_BITS+1 -: 2];
    case (w_digit)
      2'd0:    w_nib = r_r[3:0];
      2'd1:    w_nib = r_r[7:4];
      2'd2:    w_nib = r_r[11:8];
      2'd3:    w_nib = r_r[15:12];
      default: w_nib = r_r[3:0];
    endcase
  end

  // Result/flag registers, scan counter and registered display drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_r    <= 32'h0000_0000;
      r_f    <= 4'b0000;
      r_scan <= '0;
      r_an   <= 4'b1110;
      r_seg  <= 8'hC0;
    end else begin
      r_r    <= w_alu_r;
      r_f    <= w_alu_f;
      r_scan <= r_scan + SCAN_ONE;
      r_an   <= ~(4'b0001 << w_digit);
      r_seg  <= hex_to_seg(w_nib);
    end
  end

  assign F   = r_f;
  assign AN  = r_an;
  assign seg = r_seg;

endmodule

// File: tb/tb_top.sv
// Scoreboard bench for top: stimulus loads A/B/OP and queues the expected
// low result half and flags; a monitor checks F and every scanned digit.
module tb_top;

  logic        clk;
  logic        rst;
  logic        clk_A;
  logic        clk_B;
  logic        clk_F;
  logic [31:0] SW;
  logic [3:0]  F;
  logic [3:0]  AN;
  logic [7:0]  seg;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] r;
    logic [3:0]  f;
    string       name;
  } exp_t;

  exp_t q[$];
  logic mon_busy = 1'b0;

  top #(.SCAN_BITS(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .clk_A (clk_A),
    .clk_B (clk_B),
    .clk_F (clk_F),
    .SW    (SW),
    .F     (F),
    .AN    (AN),
    .seg   (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] glyph(input logic [3:0] n);
    logic [7:0] t [16];
    t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
          8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    return t[n];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation and watches a full scan period.
  initial begin
    exp_t it;
    logic [3:0] seen;
    int d;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        it = q.pop_front();
        mon_busy = 1'b1;
        seen = 4'b0000;
        check({it.name, " F"}, {28'h0, F}, {28'h0, it.f});
        for (int i = 0; i < 16; i++) begin
          d = -1;
          for (int k = 0; k < 4; k++) begin
            if (AN == ~(4'b0001 << k)) d = k;
          end
          if (d < 0) begin
            check({it.name, " AN onehot"}, {28'h0, AN}, 32'h0000_000E);
          end else begin
            seen[d] = 1'b1;
            check($sformatf("%s seg digit%0d", it.name, d), {24'h0, seg}, {24'h0, glyph(it.r[4*d +: 4])});
          end
          if (i < 15) @(negedge clk);
        end
        check({it.name, " all digits scanned"}, {28'h0, seen}, 32'h0000_000F);
        mon_busy = 1'b0;
      end
    end
  end

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (q.size() == 0 && !mon_busy) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL monitor timeout: queue %0d busy %0d required idle", q.size(), mon_busy);
    end
  endtask

  task automatic strobe(input int which, input logic [31:0] val);
    @(negedge clk);
    SW = val;
    case (which)
      0:       clk_A = 1'b1;
      1:       clk_B = 1'b1;
      default: clk_F = 1'b1;
    endcase
    repeat (5) @(negedge clk);
    clk_A = 1'b0;
    clk_B = 1'b0;
    clk_F = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic run(input string name, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] op, input logic [15:0] er, input logic [3:0] ef);
    exp_t it;
    strobe(0, a);
    strobe(1, b);
    strobe(2, {28'h0, op});
    repeat (10) @(posedge clk);
    it.r = er;
    it.f = ef;
    it.name = name;
    q.push_back(it);
    wait_idle();
  endtask

  initial begin
    exp_t it;
    rst = 1'b1; clk_A = 1'b0; clk_B = 1'b0; clk_F = 1'b0; SW = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset F", {28'h0, F}, 32'h0);
    check("reset AN", {28'h0, AN}, 32'h0000_000E);
    check("reset seg", {24'h0, seg}, 32'h0000_00C0);
    rst = 1'b0;
    @(negedge clk);
    check("F after release", {28'h0, F}, 32'h0000_0008);
    it.r = 16'h0000; it.f = 4'b1000; it.name = "idle zero";
    q.push_back(it);
    wait_idle();

    run("add carry", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0000, 16'hFFFE, 4'b0101);
    run("add 1+1",   32'h0000_0001, 32'h0000_0001, 4'b0000, 16'h0002, 4'b0000);
    run("sll",       32'h0000_0001, 32'h0000_0002, 4'b0001, 16'h0004, 4'b0000);
    run("slt neg",   32'hA000_0001, 32'h0000_0001, 4'b0010, 16'h0001, 4'b0000);
    run("slt pos",   32'h0000_0002, 32'h0000_0001, 4'b0010, 16'h0000, 4'b1000);
    run("sub ovf",   32'h8000_0000, 32'h0000_0001, 4'b1000, 16'hFFFF, 4'b0010);
    run("sub borrow",32'h0000_0000, 32'h0000_0001, 4'b1000, 16'hFFFF, 4'b0101);
    run("sra",       32'h8000_0000, 32'h0000_0004, 4'b1101, 16'h0000, 4'b0001);
    run("srl",       32'h8000_0000, 32'h0000_0004, 4'b0101, 16'h0000, 4'b0000);
    run("xor",       32'h1234_5678, 32'h0000_FFFF, 4'b0100, 16'hA987, 4'b0000);
    run("and alt",   32'h1234_5678, 32'h0000_FFFF, 4'b1111, 16'h5678, 4'b0000);
    run("or",        32'h1234_5678, 32'h0000_FFFF, 4'b0110, 16'hFFFF, 4'b0000);
    run("sltu alt",  32'h0000_0001, 32'hFFFF_FFFF, 4'b1011, 16'h0001, 4'b0000);
    run("sub eq",    32'h1357_9BDF, 32'h1357_9BDF, 4'b1000, 16'h0000, 4'b1000);

    // Long strobe with SW changing mid-hold must load only the first value.
    @(negedge clk);
    SW = 32'h0000_0005;
    clk_A = 1'b1;
    repeat (6) @(negedge clk);
    SW = 32'h0000_0007;
    repeat (10) @(negedge clk);
    clk_A = 1'b0;
    repeat (3) @(negedge clk);
    strobe(1, 32'h0000_0003);
    strobe(2, 32'h0000_0000);
    repeat (10) @(posedge clk);
    it.r = 16'h0008; it.f = 4'b0000; it.name = "held strobe";
    q.push_back(it);
    wait_idle();

    // Reset mid-strobe: the pending A load is discarded and state clears.
    @(negedge clk);
    SW = 32'h0000_0009;
    clk_A = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid reset F", {28'h0, F}, 32'h0);
    check("mid reset AN", {28'h0, AN}, 32'h0000_000E);
    check("mid reset seg", {24'h0, seg}, 32'h0000_00C0);
    clk_A = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("F after mid release", {28'h0, F}, 32'h0000_0008);
    repeat (10) @(posedge clk);
    it.r = 16'h0000; it.f = 4'b1000; it.name = "after reset";
    q.push_back(it);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
